decode_return: RTL and testbench
================================

# decode_return

Response-return path paired with the address decoder. It records the one-hot slave selection of every accepted request in an in-order FIFO, then routes each slave's ack, error and data back to the single master in issue order. Requests decoded to the non-existent slave (index NS) receive an internally generated bus error. It sits between the NS slave response ports and the master's response port, downstream of the decoder.

## Interface
- NS, 8: number of real slaves; decode bit NS is "no slave selected"
- DW, 32: response data width
- LGDEPTH, 4: log2 of the outstanding-request FIFO depth (DEPTH = 2^LGDEPTH)
- OPT_LOWPOWER, 0: force o_data to 0 whenever neither o_ack nor o_err is set
- Clock and reset: one clock; reset is asynchronous and active-low.
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_clear  in  1  synchronous flush (master dropped its cycle)
- i_req_valid  in  1  decoded request present
- i_req_decode  in  NS+1  one-hot decode of that request (bit NS = none selected)
- i_req_stall  in  1  downstream (slave side) stall
- o_req_valid  out  1  request forwarded to slaves, i_req_valid && !full && !i_clear
- o_req_stall  out  1  i_req_stall || full || i_clear
- i_sack  in  NS  per-slave ack pulse
- i_serr  in  NS  per-slave error pulse
- i_sdata  in  NS*DW  per-slave read data, slave k at [k*DW +: DW]
- o_ack  out  1  registered ack to master
- o_err  out  1  registered bus error to master
- o_data  out  DW  registered response data
- o_busy  out  1  one or more requests outstanding
- o_fault  out  1  sticky protocol fault

## Operation
- Accept: i_req_valid && !o_req_stall pushes the binary index of i_req_decode, width IW = $clog2(NS+1).
- Occupancy counter is LGDEPTH+1 bits, 0..DEPTH. full = (count == DEPTH). Full is evaluated from the registered count, with no pop bypass: a pop and a push in the same cycle at full still stall the push.
- Head index k < NS: the first cycle with i_sack[k] || i_serr[k] pops the entry.
  - Next cycle: o_err = i_serr[k], o_ack = i_sack[k] && !i_serr[k] (error wins), o_data = i_sdata[k].
- Head index NS: popped on the first cycle it is at the head. Next cycle: o_err = 1, o_ack = 0, o_data = 0.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Fault conditions set o_fault, which is cleared only by reset:
  - any i_sack or i_serr while the FIFO is empty;
  - any ack or error from a slave other than the head;
  - more than one slave responding in the same cycle. The head's own response is still honoured in this case.
- Stray responses are dropped and are never forwarded.
- i_clear:
  - count and pointers return to 0;
  - no push occurs that cycle;
  - all responses that cycle are dropped without setting fault;
  - o_ack and o_err are 0 the next cycle.
- o_busy = (count != 0).

## Timing
- Reset values: o_ack = 0, o_err = 0, o_data = 0, o_fault = 0, count = 0, o_busy = 0. o_req_valid and o_req_stall are combinational and follow their equations with count = 0.
- Slave response to master response: 1 cycle.
- Non-existent slave: push at cycle t, entry at head t+1, o_err at t+2 at the earliest. Back-to-back NS entries retire one per cycle.
- One entry retires per cycle at most. o_ack and o_err are single-cycle pulses and never both high.
- Reset asserted mid-transaction: everything clears immediately and asynchronously. Responses still in flight after reset release are faults.

## Structure
- Shared package: IW computation, the one-hot-to-index encode function, and fault-reason constants.
- Sub-module decode_return_fifo: synchronous FIFO, IW wide and 2^LGDEPTH deep, with push, pop, clear, count and full. It reuses the same asynchronous active-low reset.
- The top level holds the head-match logic, the response mux and the output registers.

## Test plan
- NS=8: requests to slaves 2, 5, 2; slaves ack in order with data 0xA, 0xB, 0xC -> o_ack at ack+1 with the same data in order; o_busy drops after the third; o_fault stays 0.
- Request decoded to bit NS at cycle t -> o_err=1 and o_data=0 at t+2; three consecutive NS requests -> three o_err pulses on consecutive cycles.
- Fill 16 entries with no acks -> o_req_stall=1 and o_req_valid=0. Then a head ack and a new request in the same cycle -> pop occurs, push is refused, and the push is accepted the next cycle.
- Slave 3 acks while slave 1 is at the head -> o_fault=1, no o_ack, entry retained. A later slave 1 ack still retires normally.
- Four outstanding requests, i_clear asserted coincident with a head ack -> no o_ack, count=0, o_fault stays 0.
- Slave 4 asserts i_sack and i_serr together at the head -> o_err=1, o_ack=0. Reset mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/decode_return_pkg.sv
// Shared definitions for the decoder response-return path: index width,
// one-hot encoder and the fault-cause bit positions.
package decode_return_pkg;

  localparam int unsigned MAX_SEL = 64;

  typedef enum int unsigned {
    FAULT_EMPTY = 0,
    FAULT_STRAY = 1,
    FAULT_MULTI = 2
  } fault_reason_e;

  localparam int unsigned N_FAULT = 3;

  function automatic int unsigned index_width(input int unsigned ns);
    return $clog2(ns + 1);
  endfunction

  // OR of set-bit positions; exact for a one-hot input.
  function automatic int unsigned onehot_to_index(input logic [MAX_SEL-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_SEL; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/decode_return_fifo.sv
// In-order FIFO of decoded slave indices for outstanding requests.
module decode_return_fifo #(
  parameter int unsigned IW      = 4,
  parameter int unsigned LGDEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic [IW-1:0]      i_data,
  input  logic               i_pop,
  output logic [IW-1:0]      o_data,
  output logic [LGDEPTH:0]   o_count,
  output logic               o_full
);

  localparam int unsigned DEPTH = 1 << LGDEPTH;

  logic [IW-1:0]      mem [DEPTH];
  logic [LGDEPTH-1:0] wr_ptr;
  logic [LGDEPTH-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign o_full  = (o_count == (LGDEPTH+1)'(DEPTH));
  assign do_push = i_push && !o_full && !i_clear;
  assign do_pop  = i_pop && (o_count != '0) && !i_clear;
  assign o_data  = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else if (i_clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

endmodule

// File: rtl/decode_return.sv
// Routes slave ack/err/data back to the master in request issue order;
// requests decoded to the non-existent slave get a generated bus error.
module decode_return
  import decode_return_pkg::*;
#(
  parameter int unsigned NS           = 8,
  parameter int unsigned DW           = 32,
  parameter int unsigned LGDEPTH      = 4,
  parameter bit          OPT_LOWPOWER = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_req_valid,
  input  logic [NS:0]      i_req_decode,
  input  logic             i_req_stall,
  output logic             o_req_valid,
  output logic             o_req_stall,
  input  logic [NS-1:0]    i_sack,
  input  logic [NS-1:0]    i_serr,
  input  logic [NS*DW-1:0] i_sdata,
  output logic             o_ack,
  output logic             o_err,
  output logic [DW-1:0]    o_data,
  output logic             o_busy,
  output logic             o_fault
);

  localparam int unsigned IW = index_width(NS);

  logic               full;
  logic               push;
  logic               pop;
  logic               empty;
  logic               head_is_ns;
  logic               head_resp;
  logic [IW-1:0]      push_idx;
  logic [IW-1:0]      head_idx;
  logic [LGDEPTH:0]   count;
  logic [NS-1:0]      resp;
  logic [NS-1:0]      head_mask;
  logic [DW-1:0]      sel_data;
  logic [N_FAULT-1:0] cause;

  assign o_req_stall = i_req_stall || full || i_clear;
  assign o_req_valid = i_req_valid && !full && !i_clear;
  assign push        = i_req_valid && !o_req_stall;
  assign push_idx    = IW'(onehot_to_index(MAX_SEL'(i_req_decode)));
  assign empty       = (count == '0);
  assign o_busy      = !empty;
  assign head_is_ns  = (head_idx == IW'(NS));
  assign resp        = i_sack | i_serr;
  assign head_resp   = |(resp & head_mask);
  assign pop         = !i_clear && !empty && (head_is_ns || head_resp);

  decode_return_fifo #(
    .IW      (IW),
    .LGDEPTH (LGDEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (i_clear),
    .i_push    (push),
    .i_data    (push_idx),
    .i_pop     (pop),
    .o_data    (head_idx),
    .o_count   (count),
    .o_full    (full)
  );

  // Head mask is empty when the FIFO is empty or the head is the NS entry,
  // so any response at those times counts as stray.
  always_comb begin
    head_mask = '0;
    sel_data  = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      if (!empty && head_idx == IW'(k)) begin
        head_mask[k] = 1'b1;
        sel_data     = i_sdata[k*DW +: DW];
      end
    end
  end

  always_comb begin
    cause              = '0;
    cause[FAULT_EMPTY] = !i_clear && empty && (|resp);
    cause[FAULT_STRAY] = !i_clear && (|(resp & ~head_mask));
    cause[FAULT_MULTI] = !i_clear && ($countones(resp) > 1);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_ack   <= 1'b0;
      o_err   <= 1'b0;
      o_data  <= '0;
      o_fault <= 1'b0;
    end else begin
      o_ack   <= pop && !head_is_ns && (|(i_sack & head_mask)) && !(|(i_serr & head_mask));
      o_err   <= pop && (head_is_ns || (|(i_serr & head_mask)));
      o_fault <= o_fault || (|cause);
      if (pop)               o_data <= head_is_ns ? '0 : sel_data;
      else if (OPT_LOWPOWER) o_data <= '0;
    end
  end

endmodule

// File: tb/tb_decode_return.sv
// Directed scoreboard bench for decode_return.
module tb_decode_return;

  localparam int unsigned NS      = 8;
  localparam int unsigned DW      = 32;
  localparam int unsigned LGDEPTH = 4;

  logic             i_clk = 1'b0;
  logic             i_reset_n;
  logic             i_clear;
  logic             i_req_valid;
  logic [NS:0]      i_req_decode;
  logic             i_req_stall;
  logic             o_req_valid;
  logic             o_req_stall;
  logic [NS-1:0]    i_sack;
  logic [NS-1:0]    i_serr;
  logic [NS*DW-1:0] i_sdata;
  logic             o_ack;
  logic             o_err;
  logic [DW-1:0]    o_data;
  logic             o_busy;
  logic             o_fault;

  typedef struct {
    logic          ack;
    logic          err;
    logic [DW-1:0] data;
    int unsigned   due;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  always #5 i_clk = ~i_clk;

  decode_return #(
    .NS           (NS),
    .DW           (DW),
    .LGDEPTH      (LGDEPTH),
    .OPT_LOWPOWER (1'b0)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clear      (i_clear),
    .i_req_valid  (i_req_valid),
    .i_req_decode (i_req_decode),
    .i_req_stall  (i_req_stall),
    .o_req_valid  (o_req_valid),
    .o_req_stall  (o_req_stall),
    .i_sack       (i_sack),
    .i_serr       (i_serr),
    .i_sdata      (i_sdata),
    .o_ack        (o_ack),
    .o_err        (o_err),
    .o_data       (o_data),
    .o_busy       (o_busy),
    .o_fault      (o_fault)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle();
    i_clear      = 1'b0;
    i_req_valid  = 1'b0;
    i_req_decode = '0;
    i_req_stall  = 1'b0;
    i_sack       = '0;
    i_serr       = '0;
    i_sdata      = '0;
  endtask

  task automatic req(input int unsigned k);
    i_req_valid     = 1'b1;
    i_req_decode    = '0;
    i_req_decode[k] = 1'b1;
  endtask

  // Request to the non-existent slave: bus error two cycles later.
  task automatic req_ns();
    exp_t e;
    req(NS);
    e.ack = 1'b0; e.err = 1'b1; e.data = '0; e.due = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic resp(input int unsigned k, input logic ack, input logic err,
                      input logic [DW-1:0] d, input bit expect_out);
    exp_t e;
    i_sack[k]           = ack;
    i_serr[k]           = err;
    i_sdata[k*DW +: DW] = d;
    if (expect_out) begin
      e.ack = ack && !err; e.err = err; e.data = d; e.due = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge i_clk);
    #1;
    cyc++;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("resp_ack", 64'(o_ack), 64'(e.ack));
      chk("resp_err", 64'(o_err), 64'(e.err));
      chk("resp_data", 64'(o_data), 64'(e.data));
    end else begin
      chk("idle_ack", 64'(o_ack), 64'd0);
      chk("idle_err", 64'(o_err), 64'd0);
    end
    idle();
  endtask

  initial begin
    idle();
    i_reset_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ack", 64'(o_ack), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_fault", 64'(o_fault), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_req_valid", 64'(o_req_valid), 64'd0);
    chk("rst_req_stall", 64'(o_req_stall), 64'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // In-order acks from slaves 2, 5, 2
    req(2); tick(); req(5); tick(); req(2); tick();
    chk("busy_three", 64'(o_busy), 64'd1);
    resp(2, 1'b1, 1'b0, 32'hA, 1'b1); tick();
    resp(5, 1'b1, 1'b0, 32'hB, 1'b1); tick();
    chk("busy_one_left", 64'(o_busy), 64'd1);
    resp(2, 1'b1, 1'b0, 32'hC, 1'b1); tick();
    chk("busy_drained", 64'(o_busy), 64'd0);
    chk("fault_clean", 64'(o_fault), 64'd0);

    // Non-existent slave, single then back-to-back
    req_ns(); tick(); tick(); tick();
    req_ns(); tick(); req_ns(); tick(); req_ns(); tick(); tick(); tick();
    chk("ns_drained", 64'(o_busy), 64'd0);

    // Fill to full, then pop and push together
    for (int i = 0; i < 16; i++) begin
      req(6); tick();
    end
    req(6);
    chk("full_stall", 64'(o_req_stall), 64'd1);
    chk("full_valid", 64'(o_req_valid), 64'd0);
    resp(6, 1'b1, 1'b0, 32'hD0, 1'b1); tick();
    req(6);
    chk("after_pop_valid", 64'(o_req_valid), 64'd1);
    chk("after_pop_stall", 64'(o_req_stall), 64'd0);
    tick();
    chk("refull_stall", 64'(o_req_stall), 64'd1);
    for (int i = 0; i < 16; i++) begin
      resp(6, 1'b1, 1'b0, 32'h100 + i, 1'b1); tick();
      if (i == 14) chk("drain_busy", 64'(o_busy), 64'd1);
    end
    chk("full_drained", 64'(o_busy), 64'd0);
    chk("fill_fault", 64'(o_fault), 64'd0);

    // Clear coincident with a head ack
    for (int i = 0; i < 4; i++) begin
      req(2); tick();
    end
    resp(2, 1'b1, 1'b0, 32'hE, 1'b0);
    i_clear = 1'b1;
    tick();
    chk("clear_busy", 64'(o_busy), 64'd0);
    chk("clear_fault", 64'(o_fault), 64'd0);
    tick();
    req(3); tick();
    resp(3, 1'b1, 1'b0, 32'hF, 1'b1); tick();
    chk("post_clear_busy", 64'(o_busy), 64'd0);

    // Ack and error together: error wins
    req(4); tick();
    resp(4, 1'b1, 1'b1, 32'h6, 1'b1); tick();
    chk("ackerr_fault", 64'(o_fault), 64'd0);

    // Stray ack from non-head slave
    req(1); tick();
    resp(3, 1'b1, 1'b0, 32'h33, 1'b0); tick();
    chk("stray_fault", 64'(o_fault), 64'd1);
    chk("stray_retained", 64'(o_busy), 64'd1);
    resp(1, 1'b1, 1'b0, 32'h11, 1'b1); tick();
    chk("stray_later_busy", 64'(o_busy), 64'd0);
    chk("fault_sticky", 64'(o_fault), 64'd1);

    // Asynchronous reset right after an ack
    req(1); tick(); req(1); tick();
    resp(1, 1'b1, 1'b0, 32'h77, 1'b1); tick();
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("arst_ack", 64'(o_ack), 64'd0);
    chk("arst_err", 64'(o_err), 64'd0);
    chk("arst_data", 64'(o_data), 64'd0);
    chk("arst_fault", 64'(o_fault), 64'd0);
    chk("arst_busy", 64'(o_busy), 64'd0);
    sb.delete();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    tick();

    // Two slaves respond at once: head honoured, fault raised
    req(2); tick();
    resp(2, 1'b1, 1'b0, 32'h22, 1'b1);
    resp(5, 1'b1, 1'b0, 32'h55, 1'b0);
    tick();
    chk("multi_fault", 64'(o_fault), 64'd1);
    chk("multi_busy", 64'(o_busy), 64'd0);
    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
